// File: rtl/expye_run_ctrl_pkg.sv
// Shared defines for the run controller: reset levels, FSM state encodings,
// and the default halt address / pass signature.
package expye_run_ctrl_pkg;

  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } run_state_e;

  localparam logic [31:0] DEF_HALT_ADDR = 32'hFFFF_FFF0;
  localparam logic [31:0] DEF_PASS_WORD = 32'h0000_0001;

endpackage

// File: rtl/expye_halt_det.sv
// Per-core halt detector: spots the first store to the magic halt address
// while armed, latches the halted flag and captures the store data as signature.
module expye_halt_det
  import expye_run_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(DEF_HALT_ADDR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_arm,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_fire,
  output logic              o_halted,
  output logic [DATA_W-1:0] o_signature
);

  logic              r_halted;
  logic [DATA_W-1:0] r_signature;
  logic              w_fire;

  // Only the first halt store counts; later ones see r_halted already set.
  assign w_fire = i_arm & i_we & (i_addr == HALT_ADDR) & ~r_halted;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_halted    <= 1'b0;
      r_signature <= '0;
    end else if (w_fire) begin
      r_halted    <= 1'b1;
      r_signature <= i_wdata;
    end
  end

  assign o_fire      = w_fire;
  assign o_halted    = r_halted;
  assign o_signature = r_signature;

endmodule

// File: rtl/expye_run_ctrl.sv
// Run controller: sequences core reset release, counts run cycles, gathers halt
// signatures and reports pass/fail. Watchdog compiled in by EXPYE_RUN_CTRL_WDT_EN.
module expye_run_ctrl
  import expye_run_ctrl_pkg::*;
#(
  parameter int                NUM_CORES       = 1,
  parameter int                ADDR_W          = 32,
  parameter int                DATA_W          = 32,
  parameter int                CNT_W           = 32,
  parameter int                RST_HOLD_CYCLES = 3,
  parameter int                TIMEOUT_CYCLES  = 30,
  parameter logic [ADDR_W-1:0] HALT_ADDR       = ADDR_W'(DEF_HALT_ADDR),
  parameter logic [DATA_W-1:0] PASS_WORD       = DATA_W'(DEF_PASS_WORD)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        mem_we,
  input  logic [NUM_CORES*ADDR_W-1:0] mem_addr,
  input  logic [NUM_CORES*DATA_W-1:0] mem_wdata,
  output logic [NUM_CORES-1:0]        core_rst,
  output logic [CNT_W-1:0]            cycle_cnt,
  output logic [NUM_CORES-1:0]        halted,
  output logic [NUM_CORES*DATA_W-1:0] signature,
  output logic                        done,
  output logic                        pass,
  output logic                        timeout
);

  localparam int                HOLD_W    = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef EXPYE_RUN_CTRL_WDT_EN
  localparam bit WDT_EN = 1'b1;
`else
  localparam bit WDT_EN = 1'b0;
`endif

  run_state_e           r_state;
  logic [HOLD_W-1:0]    r_hold_cnt;
  logic [CNT_W-1:0]     r_cycle_cnt;
  logic [NUM_CORES-1:0] r_core_rst;
  logic                 r_done;
  logic                 r_pass;
  logic                 r_timeout;

  logic                 w_arm;
  logic [NUM_CORES-1:0] w_fire;
  logic [NUM_CORES-1:0] w_halted;
  logic [NUM_CORES-1:0] w_sig_ok;

  assign w_arm = (r_state == ST_RUN);

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    expye_halt_det #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .HALT_ADDR(HALT_ADDR)
    ) u_halt_det (
      .clk        (clk),
      .rst        (rst),
      .i_arm      (w_arm),
      .i_we       (mem_we[i]),
      .i_addr     (mem_addr[i*ADDR_W +: ADDR_W]),
      .i_wdata    (mem_wdata[i*DATA_W +: DATA_W]),
      .o_fire     (w_fire[i]),
      .o_halted   (w_halted[i]),
      .o_signature(signature[i*DATA_W +: DATA_W])
    );
    assign w_sig_ok[i] = (signature[i*DATA_W +: DATA_W] == PASS_WORD);
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state     <= ST_HOLD;
      r_hold_cnt  <= '0;
      r_cycle_cnt <= '0;
      r_core_rst  <= '1;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state    <= ST_RUN;
            r_core_rst <= {NUM_CORES{RstDisable}};
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          // Completion is judged on registered flags, so the count freezes one edge after the last halt.
          if (&w_halted) begin
            r_state    <= ST_DONE;
            r_done     <= 1'b1;
            r_pass     <= &w_sig_ok;
            r_core_rst <= '1;
          end else begin
            if (r_cycle_cnt != '1) begin
              r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
            r_core_rst <= r_core_rst | w_fire;
            // A last halt landing on the budget edge takes precedence over the timeout.
            if (WDT_EN && (r_cycle_cnt == TO_LAST) && !(&(w_halted | w_fire))) begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_timeout  <= 1'b1;
              r_pass     <= 1'b0;
              r_core_rst <= '1;
            end
          end
        end
        ST_DONE: begin
          r_core_rst <= '1;
        end
        default: begin
          r_state <= ST_HOLD;
        end
      endcase
    end
  end

  assign core_rst  = r_core_rst;
  assign cycle_cnt = r_cycle_cnt;
  assign halted    = w_halted;
  assign done      = r_done;
  assign pass      = r_pass;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_expye_run_ctrl.sv
// Self-checking bench for expye_run_ctrl (two cores); expectations come from an
// outcome-level model of halt times, signatures and the run budget.
module tb_expye_run_ctrl;

  localparam int          NC     = 2;
  localparam int          AW     = 32;
  localparam int          DW     = 32;
  localparam int          CW     = 32;
  localparam int          HOLD   = 3;
  localparam int          TMO    = 30;
  localparam int          RUNLEN = 40;
  localparam logic [31:0] HALT   = 32'hFFFF_FFF0;
  localparam logic [31:0] PASSW  = 32'h0000_0001;

`ifdef EXPYE_RUN_CTRL_WDT_EN
  localparam bit WDT = 1'b1;
`else
  localparam bit WDT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NC-1:0]    memWe = '0;
  logic [NC*AW-1:0] memAddr = '0;
  logic [NC*DW-1:0] memWdata = '0;
  logic [NC-1:0]    coreRst;
  logic [CW-1:0]    cycleCnt;
  logic [NC-1:0]    haltedO;
  logic [NC*DW-1:0] signatureO;
  logic             doneO;
  logic             passO;
  logic             timeoutO;

  int testsRun = 0;
  int testsFailed = 0;

  // Scenario description: RUN cycle of each core's halt store (-1 = never) and its data.
  int          haltCyc[NC];
  logic [31:0] sigVal[NC];

  expye_run_ctrl #(
    .NUM_CORES      (NC),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .CNT_W          (CW),
    .RST_HOLD_CYCLES(HOLD),
    .TIMEOUT_CYCLES (TMO),
    .HALT_ADDR      (HALT),
    .PASS_WORD      (PASSW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_we   (memWe),
    .mem_addr (memAddr),
    .mem_wdata(memWdata),
    .core_rst (coreRst),
    .cycle_cnt(cycleCnt),
    .halted   (haltedO),
    .signature(signatureO),
    .done     (doneO),
    .pass     (passO),
    .timeout  (timeoutO)
  );

  always #5 clk = ~clk;

  // Resets the DUT, checks the reset-release sequence, then plays runLen RUN cycles.
  task automatic runScenario(input string name, input int runLen);
    logic [NC-1:0] expCr;
    logic [NC-1:0] expH;
    logic [31:0]   expSig;
    logic [31:0]   a;
    bit            counted[NC];
    bit            allHalt;
    bit            isDone;
    bit            expTo;
    bit            expPass;
    int            lastH;
    int            doneEdge;
    int            endCnt;
    int            expCnt;

    allHalt = 1'b1;
    lastH   = -1;
    expPass = 1'b1;
    for (int i = 0; i < NC; i++) begin
      counted[i] = (haltCyc[i] >= 0) && (!WDT || haltCyc[i] <= TMO - 1);
      if (!counted[i]) allHalt = 1'b0;
      else if (haltCyc[i] > lastH) lastH = haltCyc[i];
      if (sigVal[i] != PASSW) expPass = 1'b0;
    end
    if (allHalt) begin
      doneEdge = lastH + 1;
      endCnt   = lastH + 1;
      expTo    = 1'b0;
    end else if (WDT) begin
      doneEdge = TMO - 1;
      endCnt   = TMO;
      expTo    = 1'b1;
      expPass  = 1'b0;
    end else begin
      doneEdge = -1;
      endCnt   = 0;
      expTo    = 1'b0;
      expPass  = 1'b0;
    end

    rst = 1'b1;
    memWe = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int h = 0; h < HOLD; h++) begin
      @(posedge clk);
      #1;
      expCr = (h == HOLD - 1) ? '0 : '1;
      testsRun++;
      if (coreRst !== expCr || cycleCnt !== '0) begin
        testsFailed++;
        $display("[TB] FAIL %s hold edge %0d: core_rst=%b cnt=%0d, want core_rst=%b cnt=0",
                 name, h, coreRst, cycleCnt, expCr);
      end
    end

    for (int e = 0; e < runLen; e++) begin
      for (int i = 0; i < NC; i++) begin
        a = $urandom;
        if (a == HALT) a = a ^ 32'h1;
        memWe[i] = 1'b0;
        memAddr[i*AW +: AW] = a;
        memWdata[i*DW +: DW] = $urandom;
        if (e == haltCyc[i]) begin
          memWe[i] = 1'b1;
          memAddr[i*AW +: AW] = HALT;
          memWdata[i*DW +: DW] = sigVal[i];
        end else if (haltCyc[i] >= 0 && e > haltCyc[i] && $urandom_range(1, 0) == 1) begin
          memWe[i] = 1'b1;
          memAddr[i*AW +: AW] = HALT;
          memWdata[i*DW +: DW] = 32'h7;
        end else if ($urandom_range(2, 0) == 0) begin
          memWe[i] = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      isDone = (doneEdge >= 0) && (e >= doneEdge);
      expCnt = isDone ? endCnt : e + 1;
      for (int i = 0; i < NC; i++) expH[i] = counted[i] && (e >= haltCyc[i]);
      expCr = isDone ? '1 : expH;

      testsRun++;
      if (cycleCnt !== CW'(expCnt)) begin
        testsFailed++;
        $display("[TB] FAIL %s cycle_cnt @%0d: got %0d want %0d", name, e, cycleCnt, expCnt);
      end
      testsRun++;
      if (doneO !== isDone) begin
        testsFailed++;
        $display("[TB] FAIL %s done @%0d: got %b want %b", name, e, doneO, isDone);
      end
      testsRun++;
      if (haltedO !== expH) begin
        testsFailed++;
        $display("[TB] FAIL %s halted @%0d: got %b want %b", name, e, haltedO, expH);
      end
      testsRun++;
      if (coreRst !== expCr) begin
        testsFailed++;
        $display("[TB] FAIL %s core_rst @%0d: got %b want %b", name, e, coreRst, expCr);
      end
      testsRun++;
      if (timeoutO !== (isDone && expTo)) begin
        testsFailed++;
        $display("[TB] FAIL %s timeout @%0d: got %b want %b", name, e, timeoutO, isDone && expTo);
      end
      testsRun++;
      if (passO !== (isDone && expPass)) begin
        testsFailed++;
        $display("[TB] FAIL %s pass @%0d: got %b want %b", name, e, passO, isDone && expPass);
      end
      for (int i = 0; i < NC; i++) begin
        expSig = expH[i] ? sigVal[i] : 32'h0;
        testsRun++;
        if (signatureO[i*DW +: DW] !== expSig) begin
          testsFailed++;
          $display("[TB] FAIL %s signature[%0d] @%0d: got %h want %h",
                   name, i, e, signatureO[i*DW +: DW], expSig);
        end
      end
    end
    memWe = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    memWe = '0;
    repeat (3) @(posedge clk);
    #1;
    testsRun++;
    if (coreRst !== '1 || cycleCnt !== '0 || haltedO !== '0 || signatureO !== '0 ||
        doneO !== 1'b0 || passO !== 1'b0 || timeoutO !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset values: core_rst=%b cnt=%0d halted=%b sig=%h done=%b pass=%b to=%b",
               coreRst, cycleCnt, haltedO, signatureO, doneO, passO, timeoutO);
    end
  endtask

  task automatic test_single_halt();
    haltCyc[0] = 10; haltCyc[1] = 10;
    sigVal[0]  = PASSW; sigVal[1] = PASSW;
    runScenario("single_halt", RUNLEN);
    testsRun++;
    if (cycleCnt !== 32'd11 || passO !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL single_halt final: cnt=%0d pass=%b, want cnt=11 pass=1", cycleCnt, passO);
    end
  endtask

  task automatic test_mismatch();
    haltCyc[0] = 5; haltCyc[1] = 8;
    sigVal[0]  = PASSW; sigVal[1] = 32'hDEAD;
    runScenario("mismatch", RUNLEN);
    testsRun++;
    if (signatureO[31:0] !== 32'h1 || passO !== 1'b0 || doneO !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL mismatch final: sig0=%h pass=%b done=%b, want sig0=1 pass=0 done=1",
               signatureO[31:0], passO, doneO);
    end
  endtask

  task automatic test_timeout();
    haltCyc[0] = -1; haltCyc[1] = -1;
    sigVal[0]  = PASSW; sigVal[1] = PASSW;
    runScenario("no_halt", RUNLEN);
    haltCyc[0] = 4;
    runScenario("one_halt", RUNLEN);
  endtask

  task automatic test_late_halt();
    haltCyc[0] = 12; haltCyc[1] = TMO - 1;
    sigVal[0]  = PASSW; sigVal[1] = PASSW;
    runScenario("late_halt", RUNLEN);
    testsRun++;
    if (timeoutO !== 1'b0 || passO !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL late_halt final: timeout=%b pass=%b, want 0/1", timeoutO, passO);
    end
  endtask

  task automatic test_mid_reset();
    haltCyc[0] = 20; haltCyc[1] = 25;
    sigVal[0]  = PASSW; sigVal[1] = PASSW;
    runScenario("pre_reset", 12);
    rst = 1'b1;
    @(posedge clk);
    #1;
    testsRun++;
    if (coreRst !== '1 || cycleCnt !== '0 || haltedO !== '0 || signatureO !== '0 ||
        doneO !== 1'b0 || passO !== 1'b0 || timeoutO !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset values: core_rst=%b cnt=%0d halted=%b done=%b",
               coreRst, cycleCnt, haltedO, doneO);
    end
    runScenario("post_reset", RUNLEN);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NC; i++) begin
        haltCyc[i] = ($urandom_range(3, 0) == 0) ? -1 : int'($urandom_range(35, 0));
        sigVal[i]  = ($urandom_range(2, 0) == 0) ? $urandom : PASSW;
      end
      runScenario("random", RUNLEN);
    end
  endtask

  initial begin
    test_reset();
    test_single_halt();
    test_mismatch();
    test_timeout();
    test_late_halt();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/expye_run_ctrl.md
# expye_run_ctrl

Run controller for multi-core simulation and FPGA bring-up of the pipelined CPU. It sequences core reset release, counts run cycles, detects per-core halt via a store to a magic address, and reports pass/fail or timeout. It sits beside one or more `expye_cpu` instances and observes their data-memory write port. This replaces fixed-delay reset and stop logic with a parametrised, self-checking controller.

## Interface
- `NUM_CORES`, 1: number of observed cores (1..8)
- `ADDR_W`, 32: data-memory address width
- `DATA_W`, 32: data-memory write-data width
- `CNT_W`, 32: cycle counter width; must represent `TIMEOUT_CYCLES`
- `RST_HOLD_CYCLES`, 3: cycles `core_rst` stays high after `rst` falls (≥1)
- `TIMEOUT_CYCLES`, 30: RUN-cycle budget before timeout (≥1)
- `HALT_ADDR`, 32'hFFFF_FFF0: magic store address meaning "halt, wdata = signature"
- `PASS_WORD`, 32'h0000_0001: signature value meaning pass
- `clk` in 1: sole clock, rising edge
- `rst` in 1: reset, synchronous, active-high
- `mem_we` in NUM_CORES: per-core data-memory write enable
- `mem_addr` in NUM_CORES*ADDR_W: per-core write address, core i at [i*ADDR_W +: ADDR_W]
- `mem_wdata` in NUM_CORES*DATA_W: per-core write data, same packing
- `core_rst` out NUM_CORES: per-core reset to the CPUs, active-high
- `cycle_cnt` out CNT_W: RUN cycles elapsed
- `halted` out NUM_CORES: core has issued its halt store
- `signature` out NUM_CORES*DATA_W: captured halt data per core
- `done` out 1: run finished (all halted or timeout)
- `pass` out 1: valid when `done`; all signatures equal `PASS_WORD`, no timeout
- `timeout` out 1: run ended by budget exhaustion

## Operation
- FSM states: HOLD, RUN, DONE. `rst` high at an edge forces HOLD from any state, including mid-run, and clears all registers.
- Reset values: `core_rst` all ones, `cycle_cnt` 0, `halted` 0, `signature` 0, `done` 0, `pass` 0, `timeout` 0.
- HOLD: hold counter increments each edge with `rst` low. After RST_HOLD_CYCLES such edges, go to RUN and drop `core_rst` to 0 for all cores.
- RUN: `cycle_cnt` increments each edge. It saturates at all-ones.
- Halt detect, per core: `mem_we[i]` high and `mem_addr[i] == HALT_ADDR` while `halted[i]`=0. On that edge, set `halted[i]`, capture `signature[i]`, and set `core_rst[i]`=1.
- Only the first halt store counts. Later stores from a halted core are ignored. Stores to other addresses have no effect.
- RUN → DONE when all cores are halted. `pass` = AND of (signature[i] == PASS_WORD).
- RUN → DONE with `timeout`=1, `pass`=0 when `cycle_cnt` == TIMEOUT_CYCLES-1 at an edge and not all cores are halted after that edge's captures.
- Simultaneous last halt and timeout at the same edge: the halt wins, so `timeout`=0.
- DONE: sticky until `rst`. `cycle_cnt` frozen, all `core_rst` high, halt inputs ignored.

## Timing
- `rst` falls before edge 0 → `core_rst` falls after edge RST_HOLD_CYCLES-1; the first RUN edge sees `cycle_cnt`=0.
- Halt store sampled at edge k: `halted[i]`, `signature[i]`, and `core_rst[i]` are visible after edge k.
- Last core halted at edge k: `done`/`pass` are visible after edge k+1, one registered state transition.
- Timeout: `done`=`timeout`=1 visible after the edge where `cycle_cnt` was TIMEOUT_CYCLES-1.
- All outputs are registered. No combinational input-to-output path.

## Configuration
- `EXPYE_RUN_CTRL_WDT_EN` defined: the timeout watchdog is compiled in as described.
- `EXPYE_RUN_CTRL_WDT_EN` undefined: no timeout comparator. RUN exits only when all cores halt, `timeout` is tied 0, and `cycle_cnt` still counts and saturates.

## Structure
- Shared defines header (alongside `RstEnable`/`RstDisable`): FSM state encodings, default `HALT_ADDR`, default `PASS_WORD`.
- Sub-module `expye_halt_det`: one instance per core via generate. Holds the halt compare, the `halted` flop and the signature register, and outputs `halted`/`signature`.
- Top holds the FSM, hold counter, cycle counter, `core_rst` and pass reduction.

## Test plan
- Defaults, `rst` high 3 cycles then low → `core_rst` high for exactly 3 further edges, then 0; `cycle_cnt` starts at 0.
- NUM_CORES=1, store 32'h1 to 32'hFFFF_FFF0 at RUN cycle 10 → `halted`=1, `core_rst`=1 same edge; next edge `done`=1, `pass`=1, `cycle_cnt`=11 frozen.
- NUM_CORES=2: core0 stores 32'h1 at cycle 5, core1 stores 32'hDEAD at cycle 8, core0 stores 32'h7 again → `signature[0]` stays 32'h1; `done`=1, `pass`=0.
- No halt stores, TIMEOUT_CYCLES=30 → after cycle_cnt=29 edge `done`=1, `timeout`=1, `pass`=0. With `EXPYE_RUN_CTRL_WDT_EN` undefined → `done` stays 0.
- Last halt store at cycle_cnt=29 with TIMEOUT_CYCLES=30 → `timeout`=0, `pass` per signature.
- `rst` pulsed mid-RUN at cycle 12 → all outputs return to reset values, and the HOLD sequence repeats.
